fft_spectrum_buffer: RTL and testbench
======================================

Name: fft_spectrum_buffer

Overview:
- Consumer end of the FFT magnitude stream (data_modulus / data_sop / data_eop / data_valid) on clk_50m.
- Captures each complete FFT frame into a ping-pong RAM, scaled and saturated to display width. Stores only the first half of the bins, since the spectrum of a real input is symmetric.
- Serves the most recent complete frame to the HDMI spectrum renderer through a registered random-read port.
- A bank swap happens only on frame boundaries, so the renderer never sees a torn frame.

Parameters:
- FFT_N, 1024, points per FFT frame (sop..eop inclusive).
- STORE_N, 512, bins stored per frame (indices 0..STORE_N-1); must be ≤ FFT_N.
- ADDR_W, 9, log2(STORE_N).
- OUT_W, 16, stored magnitude width.
- SHIFT, 8, right shift applied to data_modulus before saturation.

Ports:
- clk_50m  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_modulus  in  32  unsigned FFT magnitude.
- data_sop  in  1  first sample of frame; qualified by data_valid.
- data_eop  in  1  last sample of frame; qualified by data_valid.
- data_valid  in  1  sample strobe.
- frame_lock  in  1  renderer is scanning the display bank; a swap is held off while high.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  bin index to read.
- rd_data  out  OUT_W  bin magnitude, registered.
- rd_valid  out  1  rd_data valid; rd_en delayed 1 cycle.
- frame_avail  out  1  sticky; a complete frame has been published since reset.
- frame_ready  out  1  1-cycle pulse on each bank swap.
- frame_cnt  out  16  published-frame counter; wraps 0xFFFF→0.
- drop_cnt  out  8  frames discarded (malformed or overwritten); saturates at 0xFF.
- err_sync  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset, asynchronous, all outputs and state:
  - rd_data=0, rd_valid=0, frame_avail=0, frame_ready=0, frame_cnt=0, drop_cnt=0, err_sync=0.
  - wr_bank=1, disp_bank=0, bin_cnt=0, pend=0, FSM=IDLE.
- Reset mid-frame abandons the frame. RAM contents are not cleared.
- Scaling:
  - s = data_modulus >> SHIFT.
  - Stored value = (s > 2^OUT_W-1) ? 2^OUT_W-1 : s[OUT_W-1:0].
- Write FSM (states IDLE, CAPTURE, PEND):
  - IDLE:
    - valid&sop: write sample at bin 0 of wr_bank, set bin_cnt=1, go to CAPTURE.
    - valid&sop&eop in the same cycle: frame length 1. If FFT_N≠1, drop the frame, drop_cnt+1, err_sync=1, stay in IDLE.
    - valid without sop: ignored.
  - CAPTURE, each valid sample:
    - Write the sample at bin_cnt only if bin_cnt<STORE_N; always increment bin_cnt.
    - valid&sop: drop the partial frame, drop_cnt+1, err_sync=1. Restart the capture with this sample as bin 0.
    - valid&eop with bin_cnt==FFT_N-1: frame good, go to PEND.
    - valid&eop with bin_cnt≠FFT_N-1: drop the frame, drop_cnt+1, err_sync=1, go to IDLE.
    - bin_cnt reaching FFT_N without eop: drop the frame, drop_cnt+1, err_sync=1, go to IDLE. Samples are ignored until the next sop.
  - PEND, swap request:
    - If frame_lock=0 in the same cycle, or the first cycle frame_lock=0 afterwards, perform the swap:
      - disp_bank←wr_bank, wr_bank←~wr_bank.
      - frame_ready=1 for that cycle, frame_avail=1, frame_cnt+1.
      - Go to IDLE.
    - valid&sop while still pending: the pending frame is overwritten. drop_cnt+1, no err_sync; capture restarts in wr_bank and the FSM goes to CAPTURE.
    - Other samples while in PEND are ignored.
- Minimum swap latency: 1 cycle after the eop sample.
- Read port:
  - rd_en at cycle t → rd_valid=1 and rd_data = RAM[disp_bank][rd_addr] at t+1.
  - If frame_avail=0 at t, rd_data=0.
  - A swap at cycle t takes effect for reads issued at t+1.
  - Read and write never touch the same bank (ping-pong), so there is no collision rule.
- RAM: 2×STORE_N×OUT_W, simple dual-port, synchronous read, 1 write port.

Test Plan:
- Good frame, frame_lock=0:
  - Stimulus: sop@bin0 with data_modulus=k<<8 for k=0..1023, eop@1023.
  - Response: frame_ready pulses 1 cycle after eop; frame_cnt=1, frame_avail=1.
  - Reading addr 5 returns 0x0005 next cycle. Reading addr 511 returns 511.
- Saturation:
  - Stimulus: bin 3 = 0x0100_0000, bin 4 = 0x00FF_FFFF.
  - Response: reads return 0xFFFF and 0xFFFF; bin 2 = 0x0000_01FF reads 0x0001.
- Short frame:
  - Stimulus: eop at bin 700.
  - Response: no frame_ready, drop_cnt=1, err_sync=1. The display bank is unchanged; reads still return the prior frame.
- Lock hold-off:
  - Stimulus: frame_lock=1 across eop, released 40 cycles later.
  - Response: frame_ready pulses on the first cycle with frame_lock=0. Reads issued during the lock return the old frame.
- Overwrite while pending:
  - Stimulus: second sop arrives while in PEND, then a second good frame, then frame_lock drops.
  - Response: drop_cnt=1, err_sync=0; the published data equals the second frame; frame_cnt increments by 1.
- Reset mid-capture:
  - Stimulus: rst_n low at bin 300, then a good frame.
  - Response: all outputs 0 during reset; rd_data=0 before the first publish. The first frame after reset publishes with frame_cnt=1.

Source files
------------

// File: rtl/fft_spectrum_buffer.sv
// Ping-pong spectrum buffer between the FFT magnitude stream and the
// HDMI spectrum renderer.
//
// Ports:
//   clk_50m, rst_n      system clock, async active-low reset
//   data_modulus        unsigned FFT magnitude (scaled, saturated on store)
//   data_sop/eop/valid  frame delimiters and sample strobe
//   frame_lock          renderer busy on display bank; holds off swaps
//   rd_en, rd_addr      random read request into the display bank
//   rd_data, rd_valid   registered read response, one cycle later
//   frame_avail         sticky, a frame has been published since reset
//   frame_ready         one-cycle pulse in the swap cycle
//   frame_cnt           published frames, wrapping
//   drop_cnt            discarded frames, saturating
//   err_sync            sticky framing error

module fft_spectrum_buffer #(
    parameter int FFT_N   = 1024,
    parameter int STORE_N = 512,
    parameter int ADDR_W  = 9,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 8
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [31:0]       data_modulus,
    input  logic              data_sop,
    input  logic              data_eop,
    input  logic              data_valid,
    input  logic              frame_lock,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OUT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              frame_avail,
    output logic              frame_ready,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        drop_cnt,
    output logic              err_sync
);

    localparam int CW = $clog2(FFT_N + 1);
    localparam logic [CW-1:0] LAST      = CW'(FFT_N - 1);
    localparam logic [CW-1:0] STORE_LIM = CW'(STORE_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_PEND
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_wr_bank;
    logic                r_disp_bank;
    logic [CW-1:0]       r_bin_cnt;
    logic                r_frame_avail;
    logic [15:0]         r_frame_cnt;
    logic [7:0]          r_drop_cnt;
    logic                r_err_sync;
    logic [OUT_W-1:0]    r_rd_data;
    logic                r_rd_valid;

    logic [OUT_W-1:0]    r_mem [0:2*STORE_N-1];

    logic                w_sop;
    logic                w_last;
    logic                w_in_store;
    logic [31:0]         w_shifted;
    logic                w_over;
    logic [OUT_W-1:0]    w_wdata;

    logic                w_we;
    logic                w_wbank;
    logic [ADDR_W-1:0]   w_waddr;
    logic                w_cnt_rst;
    logic                w_cnt_inc;
    logic                w_drop;
    logic                w_err;
    logic                w_swap;

    assign w_sop      = data_valid & data_sop;
    assign w_last     = (r_bin_cnt == LAST);
    assign w_in_store = (r_bin_cnt < STORE_LIM);

    assign w_shifted  = data_modulus >> SHIFT;
    assign w_over     = |w_shifted[31:OUT_W];
    assign w_wdata    = w_over ? '1 : w_shifted[OUT_W-1:0];

    // State register
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sop) begin
                    if (data_eop) begin
                        w_state_nxt = (FFT_N == 1) ? S_PEND : S_IDLE;
                    end else begin
                        w_state_nxt = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (data_valid) begin
                    if (data_sop) begin
                        w_state_nxt = S_CAPTURE;
                    end else if (data_eop) begin
                        w_state_nxt = w_last ? S_PEND : S_IDLE;
                    end else if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_PEND: begin
                if (w_sop) begin
                    w_state_nxt = S_CAPTURE;
                end else if (!frame_lock) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / action decode
    always_comb begin
        w_we      = 1'b0;
        w_wbank   = r_wr_bank;
        w_waddr   = '0;
        w_cnt_rst = 1'b0;
        w_cnt_inc = 1'b0;
        w_drop    = 1'b0;
        w_err     = 1'b0;
        w_swap    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sop) begin
                    w_we      = 1'b1;
                    w_cnt_rst = 1'b1;
                    if (data_eop && (FFT_N != 1)) begin
                        w_drop = 1'b1;
                        w_err  = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (data_valid) begin
                    if (data_sop) begin
                        w_we      = 1'b1;
                        w_cnt_rst = 1'b1;
                        w_drop    = 1'b1;
                        w_err     = 1'b1;
                    end else begin
                        w_we      = w_in_store;
                        w_waddr   = r_bin_cnt[ADDR_W-1:0];
                        w_cnt_inc = 1'b1;
                        // eop early, or last bin reached without eop
                        if (data_eop != w_last) begin
                            w_drop = 1'b1;
                            w_err  = 1'b1;
                        end
                    end
                end
            end
            S_PEND: begin
                w_swap = !frame_lock;
                // a capture starting in the swap cycle lands in the new bank
                w_wbank = frame_lock ? r_wr_bank : ~r_wr_bank;
                if (w_sop) begin
                    w_we      = 1'b1;
                    w_cnt_rst = 1'b1;
                    w_drop    = frame_lock;
                end
            end
            default: ;
        endcase
    end

    // Bank, counter and status registers
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank     <= 1'b1;
            r_disp_bank   <= 1'b0;
            r_bin_cnt     <= '0;
            r_frame_avail <= 1'b0;
            r_frame_cnt   <= '0;
            r_drop_cnt    <= '0;
            r_err_sync    <= 1'b0;
        end else begin
            if (w_swap) begin
                r_disp_bank   <= r_wr_bank;
                r_wr_bank     <= ~r_wr_bank;
                r_frame_avail <= 1'b1;
                r_frame_cnt   <= r_frame_cnt + 16'd1;
            end
            if (w_cnt_rst) begin
                r_bin_cnt <= CW'(1);
            end else if (w_cnt_inc) begin
                r_bin_cnt <= r_bin_cnt + CW'(1);
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_err) begin
                r_err_sync <= 1'b1;
            end
        end
    end

    // Spectrum RAM write port; contents survive reset
    always_ff @(posedge clk_50m) begin
        if (w_we) begin
            r_mem[{w_wbank, w_waddr}] <= w_wdata;
        end
    end

    // Registered read port on the display bank
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= r_frame_avail ? r_mem[{r_disp_bank, rd_addr}] : '0;
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign frame_avail = r_frame_avail;
    assign frame_ready = w_swap;
    assign frame_cnt   = r_frame_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign err_sync    = r_err_sync;

endmodule

// File: tb/tb_fft_spectrum_buffer.sv
// Testbench for fft_spectrum_buffer: frame-level reference model with a
// per-cycle compare, plus directed literal checks.

module tb_fft_spectrum_buffer;

    logic        clk_50m = 1'b0;
    logic        rst_n   = 1'b1;
    logic [31:0] data_modulus = '0;
    logic        data_sop   = 1'b0;
    logic        data_eop   = 1'b0;
    logic        data_valid = 1'b0;
    logic        frame_lock = 1'b0;
    logic        rd_en      = 1'b0;
    logic [8:0]  rd_addr    = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        frame_avail;
    logic        frame_ready;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
    logic        err_sync;

    fft_spectrum_buffer dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .data_modulus (data_modulus),
        .data_sop     (data_sop),
        .data_eop     (data_eop),
        .data_valid   (data_valid),
        .frame_lock   (frame_lock),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .frame_avail  (frame_avail),
        .frame_ready  (frame_ready),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt),
        .err_sync     (err_sync)
    );

    always #10 clk_50m = ~clk_50m;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames as queues, published frame as an array
    int   pub [512];
    int   pend_fr [512];
    int   cap [$];
    bit   m_cap, m_pend, m_avail, m_err, m_rv;
    int   m_cnt, m_drop, m_rd;

    function automatic int scale(logic [31:0] d);
        logic [31:0] s;
        s = d >> 8;
        return (s > 32'd65535) ? 65535 : int'(s);
    endfunction

    function automatic void drop_one();
        if (m_drop < 255) m_drop++;
    endfunction

    always @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            m_cap = 0; m_pend = 0; m_avail = 0; m_err = 0; m_rv = 0;
            m_cnt = 0; m_drop = 0; m_rd = 0;
            cap.delete();
        end else begin : model_step
            bit sw;
            int v;
            m_rv = rd_en;
            if (rd_en) m_rd = m_avail ? pub[rd_addr] : 0;
            sw = m_pend && !frame_lock;
            if (sw) begin
                pub = pend_fr;
                m_avail = 1;
                m_cnt = (m_cnt + 1) & 16'hFFFF;
                m_pend = 0;
            end
            if (data_valid) begin
                v = scale(data_modulus);
                if (data_sop) begin
                    if (m_cap) begin
                        drop_one(); m_err = 1;
                    end else if (m_pend) begin
                        drop_one(); m_pend = 0;
                    end
                    cap.delete();
                    cap.push_back(v);
                    m_cap = 1;
                    if (data_eop) begin
                        drop_one(); m_err = 1; m_cap = 0;
                    end
                end else if (m_cap) begin
                    cap.push_back(v);
                    if (data_eop || cap.size() == 1024) begin
                        if (data_eop && cap.size() == 1024) begin
                            for (int i = 0; i < 512; i++) pend_fr[i] = cap[i];
                            m_pend = 1;
                        end else begin
                            drop_one(); m_err = 1;
                        end
                        m_cap = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk_50m) begin
        chk("frame_ready", frame_ready, m_pend && !frame_lock);
        chk("frame_cnt",   frame_cnt,   m_cnt);
        chk("frame_avail", frame_avail, m_avail);
        chk("drop_cnt",    drop_cnt,    m_drop);
        chk("err_sync",    err_sync,    m_err);
        chk("rd_valid",    rd_valid,    m_rv);
        if (m_rv) chk("rd_data", rd_data, m_rd);
    end

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic send(input int len, input int base, input bit sat,
                        input bit eop);
        for (int k = 0; k < len; k++) begin
            tick();
            data_valid   = 1'b1;
            data_sop     = (k == 0);
            data_eop     = eop && (k == len - 1);
            data_modulus = 32'(base + k) << 8;
            if (sat) begin
                if (k == 2) data_modulus = 32'h0000_01FF;
                if (k == 3) data_modulus = 32'h0100_0000;
                if (k == 4) data_modulus = 32'h00FF_FFFF;
            end
        end
        tick();
        data_valid = 1'b0;
        data_sop   = 1'b0;
        data_eop   = 1'b0;
    endtask

    task automatic rd(input int a, output logic [15:0] d);
        tick();
        rd_en   = 1'b1;
        rd_addr = 9'(a);
        tick();
        rd_en = 1'b0;
        @(negedge clk_50m);
        d = rd_data;
    endtask

    logic [15:0] d;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        chk("reset rd_data", rd_data, 0);
        chk("reset frame_cnt", frame_cnt, 0);
        chk("reset frame_avail", frame_avail, 0);
        tick();
        rst_n = 1'b1;

        rd(5, d);
        chk("read before publish", d, 0);

        // good frame, no lock
        send(1024, 0, 0, 1);
        @(negedge clk_50m);
        chk("ready 1 cycle after eop", frame_ready, 1);
        repeat (2) tick();
        chk("good frame_cnt", frame_cnt, 1);
        chk("good frame_avail", frame_avail, 1);
        rd(5, d);   chk("good bin5", d, 16'h0005);
        rd(511, d); chk("good bin511", d, 16'd511);

        // saturation
        send(1024, 0, 1, 1);
        repeat (2) tick();
        rd(2, d); chk("sat bin2", d, 16'h0001);
        rd(3, d); chk("sat bin3", d, 16'hFFFF);
        rd(4, d); chk("sat bin4", d, 16'hFFFF);
        chk("sat frame_cnt", frame_cnt, 2);

        // short frame
        send(701, 100, 0, 1);
        @(negedge clk_50m);
        chk("short no ready", frame_ready, 0);
        repeat (2) tick();
        chk("short drop_cnt", drop_cnt, 1);
        chk("short err_sync", err_sync, 1);
        chk("short frame_cnt", frame_cnt, 2);
        rd(5, d); chk("short keeps bin5", d, 16'h0005);
        rd(3, d); chk("short keeps bin3", d, 16'hFFFF);

        // lock hold-off
        frame_lock = 1'b1;
        send(1024, 200, 0, 1);
        repeat (20) tick();
        rd(5, d); chk("locked old bin5", d, 16'h0005);
        repeat (15) tick();
        chk("locked no ready", frame_ready, 0);
        chk("locked frame_cnt", frame_cnt, 2);
        tick();
        frame_lock = 1'b0;
        @(negedge clk_50m);
        chk("ready on unlock", frame_ready, 1);
        tick();
        chk("unlock frame_cnt", frame_cnt, 3);
        rd(5, d);   chk("unlock bin5", d, 16'd205);
        rd(511, d); chk("unlock bin511", d, 16'd711);

        // reset mid-capture
        send(300, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50m);
        chk("mid rst frame_cnt", frame_cnt, 0);
        chk("mid rst avail", frame_avail, 0);
        chk("mid rst drop", drop_cnt, 0);
        chk("mid rst err", err_sync, 0);
        chk("mid rst rd_data", rd_data, 0);
        chk("mid rst rd_valid", rd_valid, 0);
        tick();
        rst_n = 1'b1;
        rd(5, d); chk("post rst read zero", d, 0);
        send(1024, 500, 0, 1);
        repeat (2) tick();
        chk("post rst frame_cnt", frame_cnt, 1);
        rd(5, d); chk("post rst bin5", d, 16'd505);

        // overwrite while pending
        frame_lock = 1'b1;
        send(1024, 600, 0, 1);
        repeat (5) tick();
        send(1024, 700, 0, 1);
        repeat (5) tick();
        chk("ovw drop_cnt", drop_cnt, 1);
        chk("ovw err_sync", err_sync, 0);
        chk("ovw held cnt", frame_cnt, 1);
        frame_lock = 1'b0;
        repeat (2) tick();
        chk("ovw frame_cnt", frame_cnt, 2);
        rd(5, d);   chk("ovw bin5", d, 16'd705);
        rd(511, d); chk("ovw bin511", d, 16'd1211);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
